// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields and a range-checked immediate
// into an I-/S-type word, one-deep output register with valid/ready handshake.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             out_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [2:0]  FMT_I    = 3'b000;
    localparam logic [2:0]  FMT_S    = 3'b001;
    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        accept;
    logic        imm_fits;
    logic        is_shift;
    logic        shift_ok;
    logic        legal;
    logic [31:0] enc_word;
    logic [31:0] next_addr;

    assign in_ready = !rst && !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // imm[31:11] all equal <=> value fits a signed 12-bit field
    assign imm_fits = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign is_shift = (in_fmt == FMT_I) && (in_opcode == OP_IMM) &&
                      ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
    assign shift_ok = (in_imm[31:12] == 20'd0) &&
                      ((in_imm[11:5] == 7'b0000000) ||
                       ((in_imm[11:5] == 7'b0100000) && (in_funct3 == 3'b101)));

    always_comb begin
        legal    = 1'b0;
        enc_word = NOP_WORD;
        case (in_fmt)
            FMT_I: begin
                legal = is_shift ? shift_ok : imm_fits;
                if (legal)
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_S: begin
                legal = imm_fits;
                if (legal)
                    enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:0], in_opcode};
            end
            default: begin
                legal    = 1'b0;
                enc_word = NOP_WORD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            out_err   <= 1'b0;
            err_count <= '0;
            next_addr <= BASE_ADDR;
        end else if (clear) begin
            out_valid <= 1'b0;
            next_addr <= BASE_ADDR;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= enc_word;
            out_addr  <= next_addr;
            out_err   <= !legal;
            next_addr <= next_addr + 32'd4;
            if (!legal && !(&err_count))
                err_count <= err_count + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encodings, range errors, back-pressure,
// streaming, clear and reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    instr_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_opcode = op;
        in_funct3 = f3;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                              input logic err, input logic [7:0] cnt);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, instr);
        check({tag, "_addr"}, out_addr, addr);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
        check({tag, "_cnt"}, {24'd0, err_count}, {24'd0, cnt});
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_funct3 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Encodings and immediate range checks
        drive(3'b000, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick(); check_word("addi", 32'h0050_0093, 32'h00, 1'b0, 8'd0);
        drive(3'b001, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        tick(); check_word("sw", 32'hFE20_AE23, 32'h04, 1'b0, 8'd0);
        drive(3'b000, 7'h13, 3'd5, 5'd3, 5'd3, 5'd0, 32'h0000_0404);
        tick(); check_word("srai", 32'h4041_D193, 32'h08, 1'b0, 8'd0);
        drive(3'b000, 7'h13, 3'd1, 5'd3, 5'd3, 5'd0, 32'h0000_0404);
        tick(); check_word("slli_bad", 32'h0000_0013, 32'h0C, 1'b1, 8'd1);
        drive(3'b000, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick(); check_word("imm_2048", 32'h0000_0013, 32'h10, 1'b1, 8'd2);
        drive(3'b000, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F7FF);
        tick(); check_word("imm_m2049", 32'h0000_0013, 32'h14, 1'b1, 8'd3);
        drive(3'b000, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
        tick(); check_word("imm_2047", 32'h7FF0_0093, 32'h18, 1'b0, 8'd3);
        drive(3'b010, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        tick(); check_word("bad_fmt", 32'h0000_0013, 32'h1C, 1'b1, 8'd4);
        in_valid = 1'b0;
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: first word held, second waits
        out_ready = 1'b0;
        drive(3'b000, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        tick(); check_word("bp_a", 32'h0010_0093, 32'h20, 1'b0, 8'd4);
        drive(3'b000, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            check_word("bp_hold", 32'h0010_0093, 32'h20, 1'b0, 8'd4);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick(); check_word("bp_b", 32'h0020_0113, 32'h24, 1'b0, 8'd4);

        // Clear while a word is held; offered input must not be taken
        out_ready = 1'b0;
        clear = 1'b1;
        drive(3'b000, 7'h13, 3'd0, 5'd9, 5'd0, 5'd0, 32'd9);
        #1;
        check("clr_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clear = 1'b0;
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check("clr_err_count", {24'd0, err_count}, 32'd4);

        // Streaming 8 words from BASE_ADDR
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] iv;
            iv = i;
            drive(3'b000, 7'h13, 3'd0, iv[4:0], 5'd0, 5'd0, iv);
            tick();
            check_word("stream", (iv << 20) | (iv << 7) | 32'h13, iv << 2, 1'b0, 8'd4);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        drive(3'b001, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        tick(); check_word("pre_rst", 32'hFE20_AE23, 32'h20, 1'b0, 8'd4);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_instr", out_instr, 32'h0);
        check("mid_rst_addr", out_addr, 32'h0);
        check("mid_rst_err", {31'd0, out_err}, 32'd0);
        check("mid_rst_cnt", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst2_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst2_addr", out_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
